// File: rtl/rvga_pipe_ctrl_if.sv
// Hazard and handshake bundle between the pipeline datapath and rvga_pipe_ctrl.
// The datapath side uses the master modport; the controller uses the slave modport.
interface rvga_pipe_ctrl_if #(
    parameter int NUM_STAGES = 6
);
    logic                  imem_req_v_i;
    logic                  imem_resp_v_i;
    logic                  dmem_req_v_i;
    logic                  dmem_resp_v_i;
    logic                  ld_use_v_i;
    logic                  btaken_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic [NUM_STAGES-1:0] stage_v_o;
    logic                  retire_v_o;
    logic [31:0]           retire_cnt_o;
    logic                  timeout_o;

    modport master (
        output imem_req_v_i, imem_resp_v_i, dmem_req_v_i, dmem_resp_v_i, ld_use_v_i, btaken_i,
        input  stall_o, flush_o, stage_v_o, retire_v_o, retire_cnt_o, timeout_o
    );

    modport slave (
        input  imem_req_v_i, imem_resp_v_i, dmem_req_v_i, dmem_resp_v_i, ld_use_v_i, btaken_i,
        output stall_o, flush_o, stage_v_o, retire_v_o, retire_cnt_o, timeout_o
    );
endinterface

// File: rtl/rvga_pipe_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, load-use and branch-flush strobes,
// per-stage valid tracking, retire counter and a sticky wait watchdog.
module rvga_pipe_ctrl #(
    parameter int NUM_STAGES     = 6,
    parameter int MEM_STAGE      = 4,
    parameter int BR_STAGE       = 4,
    parameter int LU_STAGE       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    rvga_pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, IWAIT, DWAIT, HALT} state_t;

    localparam logic [NUM_STAGES-1:0] MEM_MASK  = NUM_STAGES'((32'd1 << (MEM_STAGE + 1)) - 32'd1);
    localparam logic [NUM_STAGES-1:0] LU_MASK   = NUM_STAGES'((32'd1 << (LU_STAGE + 1)) - 32'd1);
    localparam logic [NUM_STAGES-1:0] BR_MASK   = NUM_STAGES'((32'd1 << BR_STAGE) - 32'd1);
    localparam logic [16:0]           TIMEOUT_W = 17'(TIMEOUT_CYCLES);

    state_t                state_q;
    logic [15:0]           wait_q;
    logic [16:0]           wait_inc;
    logic [NUM_STAGES-1:0] stage_v_q;
    logic [NUM_STAGES-1:0] raw_stall;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic [31:0]           retire_cnt_q;
    logic                  timeout_q;
    logic                  dwait_cond;
    logic                  iwait_cond;
    logic                  dmem_wait;
    logic                  imem_wait;
    logic                  lu_stall;
    logic                  br_flush;
    logic                  retire_v;
    logic                  wait_cycle;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        dmem_wait  = 1'b0;
        imem_wait  = 1'b0;
        dwait_cond = bus.dmem_req_v_i & stage_v_q[MEM_STAGE] & ~bus.dmem_resp_v_i;
        iwait_cond = bus.imem_req_v_i & ~bus.imem_resp_v_i;

        // A wait state holds on its own response; the other miss still comes from live requests.
        case (state_q)
            RUN: begin
                dmem_wait = dwait_cond;
                imem_wait = iwait_cond;
            end
            IWAIT: begin
                dmem_wait = dwait_cond;
                imem_wait = ~bus.imem_resp_v_i;
            end
            DWAIT: begin
                dmem_wait = ~bus.dmem_resp_v_i;
                imem_wait = iwait_cond;
            end
            default: ;
        endcase

        lu_stall  = bus.ld_use_v_i & stage_v_q[LU_STAGE] & ~dmem_wait;
        raw_stall = ({NUM_STAGES{dmem_wait}} & MEM_MASK)
                  | ({NUM_STAGES{lu_stall}} & LU_MASK)
                  | {{(NUM_STAGES-1){1'b0}}, imem_wait};

        // A stalled branch stage re-presents its outcome later, so only an advancing branch flushes.
        br_flush = bus.btaken_i & stage_v_q[BR_STAGE] & ~raw_stall[BR_STAGE];
        flush    = {NUM_STAGES{br_flush}} & BR_MASK;
        stall    = raw_stall & ~flush;

        if (state_q == HALT) begin
            stall = '1;
            flush = '0;
        end
        if (rst_i) begin
            stall = '0;
            flush = '0;
        end

        retire_v   = stage_v_q[NUM_STAGES-1] & ~stall[NUM_STAGES-1] & ~rst_i;
        wait_cycle = dmem_wait | imem_wait;
        wait_inc   = {1'b0, wait_q} + 17'd1;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q      <= RUN;
            wait_q       <= '0;
            stage_v_q    <= NUM_STAGES'(1);
            retire_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (retire_v) retire_cnt_q <= retire_cnt_q + 32'd1;

            stage_v_q[0] <= 1'b1;
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (!stall[i]) stage_v_q[i] <= stage_v_q[i-1] & ~stall[i-1] & ~flush[i-1];
            end

            // The wait counter spans back-to-back IWAIT/DWAIT residency and clears on return to RUN.
            case (state_q)
                HALT: ;
                default: begin
                    if (!wait_cycle) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_inc >= TIMEOUT_W) begin
                        state_q   <= HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q <= dmem_wait ? DWAIT : IWAIT;
                        wait_q  <= wait_inc[15:0];
                    end
                end
            endcase
        end
    end

    assign bus.stall_o      = stall;
    assign bus.flush_o      = flush;
    assign bus.stage_v_o    = stage_v_q;
    assign bus.retire_v_o   = retire_v;
    assign bus.retire_cnt_o = retire_cnt_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_rvga_pipe_ctrl.sv
// Directed plus randomized bench for rvga_pipe_ctrl against a per-stage behavioural model.
module tb_rvga_pipe_ctrl;
    localparam int N   = 6;
    localparam int MEM = 4;
    localparam int BR  = 4;
    localparam int LU  = 2;
    localparam int TO  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvga_pipe_ctrl_if #(.NUM_STAGES(N)) pif ();

    rvga_pipe_ctrl #(
        .NUM_STAGES(N), .MEM_STAGE(MEM), .BR_STAGE(BR), .LU_STAGE(LU), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (pif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: valid per stage, retire count, consecutive miss cycles, pending-miss flags.
    logic [N-1:0] mv;
    logic [31:0]  mcnt;
    int           mwait;
    bit           mhalt, mdpend, mipend, m_known;
    logic [N-1:0] e_stall, e_flush;
    logic         e_ret, e_dmiss, e_imiss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic apply(input bit r, input bit ireq, input bit iresp, input bit dreq,
                         input bit dresp, input bit lu, input bit bt);
        bit luh, br;
        rst               = r;
        pif.imem_req_v_i  = ireq;
        pif.imem_resp_v_i = iresp;
        pif.dmem_req_v_i  = dreq;
        pif.dmem_resp_v_i = dresp;
        pif.ld_use_v_i    = lu;
        pif.btaken_i      = bt;
        e_stall = '0;
        e_flush = '0;
        e_ret   = 1'b0;
        e_dmiss = 1'b0;
        e_imiss = 1'b0;
        if (!r && mhalt) begin
            e_stall = '1;
        end else if (!r) begin
            e_dmiss = mdpend ? !dresp : (dreq && mv[MEM] && !dresp);
            e_imiss = mipend ? !iresp : (ireq && !iresp);
            luh     = lu && mv[LU] && !e_dmiss;
            for (int i = 0; i < N; i++)
                e_stall[i] = (e_dmiss && i <= MEM) || (luh && i <= LU) || (e_imiss && i == 0);
            br = bt && mv[BR] && !e_stall[BR];
            for (int i = 0; i < BR; i++) begin
                if (br) begin
                    e_flush[i] = 1'b1;
                    e_stall[i] = 1'b0;
                end
            end
            e_ret = mv[N-1] && !e_stall[N-1];
        end
        #1;
        check("stall", pif.stall_o, e_stall);
        check("flush", pif.flush_o, e_flush);
        check("retire_v", pif.retire_v_o, e_ret);
        if (m_known) begin
            check("stage_v", pif.stage_v_o, mv);
            check("retire_cnt", pif.retire_cnt_o, mcnt);
            check("timeout", pif.timeout_o, mhalt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mv      = '0;
            mv[0]   = 1'b1;
            mcnt    = '0;
            mwait   = 0;
            mhalt   = 1'b0;
            mdpend  = 1'b0;
            mipend  = 1'b0;
            m_known = 1'b1;
        end else if (!mhalt) begin
            for (int i = N - 1; i >= 1; i--)
                if (!e_stall[i]) mv[i] = mv[i-1] && !e_stall[i-1] && !e_flush[i-1];
            if (e_ret) mcnt = mcnt + 32'd1;
            if (e_dmiss || e_imiss) mwait++;
            else mwait = 0;
            mhalt  = (mwait >= TO);
            mdpend = !mhalt && e_dmiss;
            mipend = !mhalt && !e_dmiss && e_imiss;
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(0, 1, 1, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        logic [31:0] exp_w;
        m_known = 1'b0;
        mhalt   = 1'b0;
        mdpend  = 1'b0;
        mipend  = 1'b0;
        mv      = '0;
        mcnt    = '0;
        mwait   = 0;
        @(negedge clk);

        // Reset: strobes low while held, single valid at ifetch afterwards.
        apply(1, 0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 0, 1, 0, 1, 1);
        check("rst_stall", pif.stall_o, 6'b000000);
        check("rst_flush", pif.flush_o, 6'b000000);
        tick();
        check("rst_stage_v", pif.stage_v_o, 6'b000001);

        // Fill with same-cycle fetch responses: all valid after 5 edges, 5 retires after 10.
        run_idle(5);
        check("fill_stage_v", pif.stage_v_o, 6'b111111);
        run_idle(5);
        check("fill_retire_cnt", pif.retire_cnt_o, 32'd5);

        // Data miss with response three cycles late.
        apply(0, 1, 1, 1, 0, 0, 0);
        check("dw_stall_1", pif.stall_o, 6'b011111);
        tick();
        apply(0, 1, 1, 0, 0, 0, 0);
        check("dw_stall_2", pif.stall_o, 6'b011111);
        check("dw_bubble_1", pif.stage_v_o[5], 1'b0);
        tick();
        apply(0, 1, 1, 1, 0, 0, 0);
        check("dw_stall_3", pif.stall_o, 6'b011111);
        check("dw_bubble_2", pif.stage_v_o[5], 1'b0);
        tick();
        apply(0, 1, 1, 1, 1, 0, 0);
        check("dw_resp_stall", pif.stall_o, 6'b000000);
        check("dw_bubble_3", pif.stage_v_o[5], 1'b0);
        tick();
        apply(0, 1, 1, 0, 0, 0, 0);
        check("dw_run_stall", pif.stall_o, 6'b000000);
        check("dw_drained", pif.stage_v_o[5], 1'b1);
        tick();

        // Taken branch at the resolve stage.
        run_idle(3);
        apply(0, 1, 1, 0, 0, 0, 1);
        check("br_flush", pif.flush_o, 6'b001111);
        check("br_stall", pif.stall_o, 6'b000000);
        tick();
        check("br_next_v", pif.stage_v_o[3:0], 4'b0001);

        // Load-use alongside a fetch miss, then fetch-only stall until the response.
        run_idle(5);
        apply(0, 1, 0, 0, 0, 1, 0);
        check("lu_imiss", pif.stall_o, 6'b000111);
        tick();
        apply(0, 1, 0, 0, 0, 0, 0);
        check("iw_stall_1", pif.stall_o, 6'b000001);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("iw_stall_2", pif.stall_o, 6'b000001);
        tick();
        apply(0, 1, 1, 0, 0, 0, 0);
        check("iw_resp", pif.stall_o, 6'b000000);
        tick();

        // Watchdog: data response never arrives.
        run_idle(5);
        for (int k = 0; k < TO; k++) begin
            apply(0, 1, 1, 1, 0, 0, 0);
            check("to_wait", pif.stall_o, 6'b011111);
            tick();
        end
        apply(0, 1, 1, 1, 0, 1, 1);
        check("halt_stall", pif.stall_o, 6'b111111);
        check("halt_flush", pif.flush_o, 6'b000000);
        check("halt_timeout", pif.timeout_o, 1'b1);
        check("halt_retire", pif.retire_v_o, 1'b0);
        tick();
        apply(1, 1, 1, 1, 0, 0, 0);
        check("halt_rst_stall", pif.stall_o, 6'b000000);
        tick();
        check("rst_timeout", pif.timeout_o, 1'b0);
        check("rst_stage_v2", pif.stage_v_o, 6'b000001);
        check("rst_cnt", pif.retire_cnt_o, 32'd0);
        apply(0, 1, 1, 1, 0, 0, 0);
        check("rst_no_residual", pif.stall_o, 6'b000000);
        tick();

        // Retire counter wrap from a preloaded value.
        run_idle(6);
        force dut.retire_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.retire_cnt_q;
        mcnt = 32'hFFFF_FFFD;
        exp_w = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 1, 0, 0, 0, 0);
            check("wrap_stall", pif.stall_o, 6'b000000);
            tick();
            exp_w = exp_w + 32'd1;
            check("wrap_cnt", pif.retire_cnt_o, exp_w);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bit r;
            r = mhalt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            apply(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
